// File: rtl/iterative_muldiv.sv
// Multi-cycle signed/unsigned multiply and divide, one bit per cycle.
// Holds devwait high while running; hi/lo update only when the result is ready.
module iterative_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             request,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             devwait,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state, w_next_state;
  logic [CW-1:0]        r_count;
  logic                 r_is_div, r_neg_q, r_neg_r, r_div_zero;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;

  // Accept-time operand conditioning: op[0]=0 selects the signed flavour.
  logic                 w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]     w_a_mag, w_b_mag;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & opA[WIDTH-1];
  assign w_b_neg  = w_signed & opB[WIDTH-1];
  assign w_a_mag  = w_a_neg ? ('0 - opA) : opA;
  assign w_b_mag  = w_b_neg ? ('0 - opB) : opB;

  // Multiply step: conditional add into the upper half, then shift right.
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: acc holds {remainder, dividend bits / quotient bits}.
  logic [WIDTH:0]       w_cand;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_diff;
  logic [2*WIDTH-1:0]   w_div_next;

  assign w_cand     = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = (w_cand >= {1'b0, r_b});
  assign w_diff     = w_cand[WIDTH-1:0] - r_b;
  assign w_div_next = {(w_ge ? w_diff : w_cand[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  logic [2*WIDTH-1:0]   w_step, w_prod;
  logic [WIDTH-1:0]     w_quot, w_rem, w_hi_next, w_lo_next;

  assign w_step    = r_is_div ? w_div_next : w_mul_next;
  assign w_prod    = r_neg_q ? ('0 - w_step) : w_step;
  assign w_quot    = r_div_zero ? '1 : (r_neg_q ? ('0 - w_step[WIDTH-1:0]) : w_step[WIDTH-1:0]);
  assign w_rem     = r_neg_r ? ('0 - w_step[2*WIDTH-1:WIDTH]) : w_step[2*WIDTH-1:WIDTH];
  assign w_hi_next = r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
  assign w_lo_next = r_is_div ? w_quot : w_prod[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (request) w_next_state = S_RUN;
      S_RUN:   if (r_count == CW'(1)) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    devwait = (r_state == S_RUN);
  end

  // NOTE: every datapath register is cleared by reset, so an abandoned
  // operation can never leak a partial result into hi/lo afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_b        <= '0;
      r_acc      <= '0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (request) begin
          r_count    <= CW'(WIDTH);
          r_is_div   <= op[1];
          r_neg_q    <= w_a_neg ^ w_b_neg;
          r_neg_r    <= w_a_neg;
          r_div_zero <= op[1] & (opB == '0);
          r_b        <= w_b_mag;
          r_acc      <= {{WIDTH{1'b0}}, w_a_mag};
        end
        S_RUN: begin
          r_acc   <= w_step;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            hi <= w_hi_next;
            lo <= w_lo_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_muldiv.sv
// Directed bench for iterative_muldiv: latency, results, handshake and reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_iterative_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         request;
  logic [1:0]   op;
  logic [W-1:0] opA, opB;
  logic         devwait;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  iterative_muldiv #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .request (request),
    .op      (op),
    .opA     (opA),
    .opB     (opB),
    .devwait (devwait),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  // Pipeline-side stall circuit model: T remembers that a stall is in progress.
  logic t_reg;
  logic stalled;
  assign stalled = t_reg ? devwait : request;
  always @(posedge clk or posedge reset) begin
    if (reset) t_reg <= 1'b0;
    else       t_reg <= stalled;
  end

  // Issue one op, check devwait for cycles 1..W+1 and hi/lo in cycle W+1.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input string name, input bit hold);
    int first_bad;
    first_bad = -1;
    @(negedge clk);
    request = 1'b1; op = o; opA = a; opB = b;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (devwait !== (k <= W) && first_bad < 0) first_bad = k;
    end
    total++;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL %s latency: devwait wrong first in cycle %0d, want 1 in cycles 1..%0d and 0 in %0d",
               name, first_bad, W, W + 1);
    end
    total++;
    if (hi !== eh) begin
      bad++;
      $display("FAIL %s hi: got %h want %h", name, hi, eh);
    end
    total++;
    if (lo !== el) begin
      bad++;
      $display("FAIL %s lo: got %h want %h", name, lo, el);
    end
    if (!hold) request = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; request = 1'b0; op = 2'b00; opA = '0; opB = '0;
    #1;
    total++;
    if ({devwait, hi, lo} !== '0) begin
      bad++;
      $display("FAIL reset_state: devwait=%b hi=%h lo=%h want all 0", devwait, hi, lo);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({devwait, hi, lo} !== '0) begin
      bad++;
      $display("FAIL after_reset_idle: devwait=%b hi=%h lo=%h want all 0", devwait, hi, lo);
    end
  endtask

  task automatic test_multu_max();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 1'b0);
  endtask

  // request stays high through DONE: no restart there, restart in the next IDLE cycle.
  task automatic test_mult_hold();
    bit done;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5", 1'b1);
    @(negedge clk);
    total++;
    if (devwait !== 1'b0) begin
      bad++;
      $display("FAIL done_no_restart: devwait=%b in cycle after DONE, want 0", devwait);
    end
    @(negedge clk);
    total++;
    if (devwait !== 1'b1) begin
      bad++;
      $display("FAIL idle_restart: devwait=%b, want 1", devwait);
    end
    request = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (devwait === 1'b0) done = 1'b1;
    end
    total++;
    if (!done || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      bad++;
      $display("FAIL restart_result: done=%b hi=%h lo=%h want done=1 hi=ffffffff lo=fffffff1",
               done, hi, lo);
    end
  endtask

  task automatic test_divide();
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2",   1'b0);
    run_op(2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        "divu_100_7",   1'b0);
    run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, "div_7_neg2",   1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h10,       32'hF,         32'h0FFF_FFFF, "divu_big_16",  1'b0);
  endtask

  task automatic test_div_corner();
    run_op(2'b11, 32'd123,       32'd0,         32'd123,       32'hFFFF_FFFF, "divu_by_zero", 1'b0);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_by_zero",  1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_overflow", 1'b0);
  endtask

  // Stage squashed mid-run: the operation still completes and writes hi/lo.
  task automatic test_squash();
    int first_bad;
    first_bad = -1;
    @(negedge clk);
    request = 1'b1; op = 2'b11; opA = 32'd100; opB = 32'd7;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k == 3) request = 1'b0;
      if (devwait !== (k <= W) && first_bad < 0) first_bad = k;
    end
    total++;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL squash latency: devwait wrong first in cycle %0d", first_bad);
    end
    total++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      bad++;
      $display("FAIL squash_result: hi=%h lo=%h want hi=00000002 lo=0000000e", hi, lo);
    end
  endtask

  // Stall circuit view: stalled=1 for cycles 0..W, old hi/lo visible until cycle W+1.
  task automatic test_handshake(input logic [W-1:0] prev_hi, input logic [W-1:0] prev_lo);
    int stall_bad, hold_bad;
    stall_bad = -1; hold_bad = -1;
    @(negedge clk);
    request = 1'b1; op = 2'b00; opA = 32'hFFFF_FFFC; opB = 32'hFFFF_FFFA;
    #1;
    if (stalled !== 1'b1) stall_bad = 0;
    if (hi !== prev_hi || lo !== prev_lo) hold_bad = 0;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (stalled !== (k <= W) && stall_bad < 0) stall_bad = k;
      if (k <= W && (hi !== prev_hi || lo !== prev_lo) && hold_bad < 0) hold_bad = k;
    end
    total++;
    if (stall_bad >= 0) begin
      bad++;
      $display("FAIL handshake_stall: stalled wrong first in cycle %0d, want 1 for 0..%0d, 0 in %0d",
               stall_bad, W, W + 1);
    end
    total++;
    if (hold_bad >= 0) begin
      bad++;
      $display("FAIL handshake_hold: hi/lo changed in cycle %0d, want %h/%h until cycle %0d",
               hold_bad, prev_hi, prev_lo, W + 1);
    end
    total++;
    if (hi !== 32'd0 || lo !== 32'd24) begin
      bad++;
      $display("FAIL handshake_result: hi=%h lo=%h want hi=00000000 lo=00000018", hi, lo);
    end
    request = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int late;
    late = -1;
    @(negedge clk);
    request = 1'b1; op = 2'b01; opA = 32'd7; opB = 32'd9;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({devwait, hi, lo} !== '0) begin
      bad++;
      $display("FAIL reset_mid_run: devwait=%b hi=%h lo=%h want all 0", devwait, hi, lo);
    end
    request = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ({devwait, hi, lo} !== '0 && late < 0) late = k;
    end
    total++;
    if (late >= 0) begin
      bad++;
      $display("FAIL reset_no_late_write: activity %0d cycles after release, devwait=%b hi=%h lo=%h want all 0",
               late, devwait, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult_hold();
    test_divide();
    test_div_corner();
    test_squash();
    test_handshake(32'd2, 32'd14);
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iterative_muldiv.md
Name: iterative_muldiv

Overview:
Multi-cycle multiply/divide responder. It is the device side of the processor's multi-cycle stall handshake: the pipeline stage drives request, and this block drives devwait until its result is ready. It computes signed and unsigned WIDTH x WIDTH products and quotient/remainder pairs, one bit per cycle. Results land in hi/lo registers that the execute stage reads when the stall releases.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
request  input  1  stage requests an operation; level, held by the stage until the stall releases
op  input  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu
opA  input  WIDTH  multiplicand or dividend; sampled only on accept
opB  input  WIDTH  multiplier or divisor; sampled only on accept
devwait  output  1  1 = result not ready; stage must stay stalled
hi  output  WIDTH  product upper half, or remainder
lo  output  WIDTH  product lower half, or quotient

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation): state=IDLE, count=0, devwait=0, hi=0, lo=0, internal datapath registers=0. An in-flight operation is abandoned.
- States:
  - IDLE: devwait=0. If request=1, accept: capture op and operand magnitudes (absolute value when op is signed), record result signs, load count=WIDTH, go to RUN. Otherwise stay.
  - RUN: devwait=1. Each cycle performs one shift-add (multiply) or one restoring shift-subtract (divide) step and decrements count. On the step where count goes 1->0, apply sign correction, write hi/lo, go to DONE.
  - DONE: devwait=0, hi/lo valid. request is ignored here: it is still high from the same instruction. Next state is IDLE unconditionally.
- Timing. Accept cycle = cycle 0. devwait is 1 in cycles 1..WIDTH and 0 in cycle WIDTH+1. hi/lo are valid from cycle WIDTH+1 and hold until the next write. devwait is don't-care to the stall circuit in cycle 0.
- Back-to-back: request=1 in the IDLE cycle that follows DONE starts a new operation. This is the new instruction.
- request dropping during RUN (for example, the stage is squashed): the operation still completes and hi/lo are updated.
- hi/lo are not modified while in RUN; intermediate values stay in internal registers. The old result stays readable until the DONE write.
- Multiply: {hi,lo} = full 2*WIDTH-bit product. Signed: negate the 2*WIDTH-bit magnitude product when the operand signs differ.
- Divide: lo = quotient truncated toward zero; hi = remainder, whose sign follows the dividend. Signed: negate the quotient when the operand signs differ; negate the remainder when the dividend is negative.
- Divide by zero (any signedness): lo = all ones, hi = opA as sampled. Latency is unchanged.
- Signed overflow, most-negative / -1: lo = 1 followed by WIDTH-1 zeros (wraps), hi = 0.
- Internal count width = clog2(WIDTH+1). No arithmetic exceptions are reported.

Test Plan:
- Reset mid-RUN: accept multu 7*9, assert reset in cycle 10 -> devwait=0, hi=lo=0 immediately. After release, state is IDLE and there is no late write.
- multu 0xFFFFFFFF*0xFFFFFFFF -> devwait=1 in cycles 1..32, 0 in cycle 33; hi=0xFFFFFFFE, lo=0x00000001 in cycle 33.
- mult -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then with request held high through DONE -> no restart in DONE; restart only in the following IDLE cycle.
- div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2.
- divu 123/0 and div -5/0 -> lo=0xFFFFFFFF with hi=123 and hi=0xFFFFFFFB respectively. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake with the stall circuit (T register, stalled = T ? devwait : request): request held until release -> stalled=1 for exactly cycles 0..32, 0 in cycle 33; hi/lo from the prior op remain unchanged through cycle 32.
